// File: rtl/acc_job_arbiter.sv
// Round-robin arbiter sharing one wrapping accumulator among NREQ job streams.
// One job is granted at a time; its beats are summed and returned with id and beat count.
module acc_job_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*DATA_W-1:0]   in_data,
  input  logic [NREQ-1:0]          in_last,
  output logic [NREQ-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [CNT_W-1:0]         out_cnt,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
  localparam logic [ID_W:0]    NREQ_EXT = (ID_W + 1)'(NREQ);
  localparam logic [NREQ-1:0]  ONEHOT0  = NREQ'(1);

  state_t              state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     gnt_r;
  logic [DATA_W-1:0]   acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [NREQ-1:0]     in_ready_r;
  logic                busy_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [ID_W-1:0]     out_id_r;
  logic [CNT_W-1:0]    out_cnt_r;

  logic [2*NREQ-1:0]   vld_dbl_s;
  logic [NREQ-1:0]     vld_rot_s;
  logic [ID_W-1:0]     off_s;
  logic [ID_W:0]       win_sum_s;
  logic [ID_W-1:0]     winner_s;
  logic                any_valid_s;
  logic [NREQ-1:0]     win_onehot_s;

  logic [DATA_W-1:0]   cur_data_s;
  logic                cur_valid_s;
  logic                cur_last_s;
  logic                hs_s;
  logic [DATA_W-1:0]   acc_sum_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [ID_W-1:0]     next_ptr_s;

  // Rotate the request vector so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    vld_dbl_s   = {in_valid, in_valid} >> rr_ptr_r;
    vld_rot_s   = vld_dbl_s[NREQ-1:0];
    off_s       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (vld_rot_s[i]) begin
        off_s = ID_W'(i);
      end else begin
        off_s = off_s;
      end
    end
    win_sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (win_sum_s >= NREQ_EXT) begin
      winner_s = ID_W'(win_sum_s - NREQ_EXT);
    end else begin
      winner_s = win_sum_s[ID_W-1:0];
    end
    any_valid_s  = |in_valid;
    win_onehot_s = ONEHOT0 << winner_s;
  end

  // Granted requester's beat, handshake and next accumulator / counter values.
  always_comb begin
    cur_data_s  = '0;
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_r == ID_W'(i)) begin
        cur_data_s  = in_data[i*DATA_W +: DATA_W];
        cur_valid_s = in_valid[i];
        cur_last_s  = in_last[i];
      end else begin
        cur_data_s  = cur_data_s;
        cur_valid_s = cur_valid_s;
        cur_last_s  = cur_last_s;
      end
    end
    hs_s      = (state_r == ST_ACCUM) && cur_valid_s;
    acc_sum_s = acc_r + cur_data_s;
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
    if (gnt_r == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_r + ID_ONE;
    end
  end

  // Job FSM with all outputs registered; in_ready is one-hot on the grant only in ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      gnt_r       <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      out_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            gnt_r      <= winner_s;
            acc_r      <= '0;
            cnt_r      <= '0;
            in_ready_r <= win_onehot_s;
            busy_r     <= 1'b1;
            state_r    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (hs_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_inc_s;
            if (cur_last_s) begin
              out_data_r  <= acc_sum_s;
              out_cnt_r   <= cnt_inc_s;
              out_id_r    <= gnt_r;
              out_valid_r <= 1'b1;
              in_ready_r  <= '0;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            rr_ptr_r    <= next_ptr_s;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= '0;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Accept is withheld combinationally while reset is asserted.
  assign in_ready  = in_ready_r & {NREQ{~rst}};
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign out_cnt   = out_cnt_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Randomized bench for acc_job_arbiter against a job-level round-robin / summing model.
module tb_acc_job_arbiter;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        in_valid;
  logic [NREQ*DATA_W-1:0] in_data;
  logic [NREQ-1:0]        in_last;
  logic [NREQ-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [ID_W-1:0]        out_id;
  logic [CNT_W-1:0]       out_cnt;
  logic                   out_ready;
  logic                   busy;

  always #5 clk = ~clk;

  acc_job_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_cnt(out_cnt),
    .out_ready(out_ready), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  logic [DATA_W-1:0] beat_q [NREQ][$];
  bit                last_q [NREQ][$];
  logic [DATA_W-1:0] m_sum  [NREQ][$];
  int                m_cnt  [NREQ][$];
  int                exp_id_q[$];
  logic [DATA_W-1:0] exp_sum_q[$];
  int                exp_cnt_q[$];

  task automatic push_beat(input int r, input logic [DATA_W-1:0] d, input bit last);
    beat_q[r].push_back(d);
    last_q[r].push_back(last);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    case ($urandom_range(5))
      0: rand_word = 32'h7FFF_FFFF;
      1: rand_word = 32'hFFFF_FFFF;
      2: rand_word = 32'h8000_0000;
      default: rand_word = $urandom;
    endcase
  endfunction

  task automatic push_rand_job(input int r, input int len);
    for (int k = 0; k < len; k++) push_beat(r, rand_word(), k == len - 1);
  endtask

  // Job-level model: sum each job, then serve pending requesters round-robin from model_ptr.
  task automatic model_expect();
    logic [DATA_W-1:0] s;
    int n, ptr, rr;
    bit found;
    exp_id_q.delete(); exp_sum_q.delete(); exp_cnt_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      m_sum[r].delete(); m_cnt[r].delete();
      s = '0; n = 0;
      for (int k = 0; k < beat_q[r].size(); k++) begin
        s = s + beat_q[r][k];
        n++;
        if (last_q[r][k]) begin
          m_sum[r].push_back(s);
          m_cnt[r].push_back(n > CNT_SAT ? CNT_SAT : n);
          s = '0; n = 0;
        end
      end
    end
    ptr = model_ptr;
    do begin
      found = 1'b0;
      for (int off = 0; off < NREQ && !found; off++) begin
        rr = (ptr + off) % NREQ;
        if (m_sum[rr].size() > 0) begin
          found = 1'b1;
          exp_id_q.push_back(rr);
          exp_sum_q.push_back(m_sum[rr].pop_front());
          exp_cnt_q.push_back(m_cnt[rr].pop_front());
          ptr = (rr + 1) % NREQ;
        end
      end
    end while (found);
    model_ptr = ptr;
  endtask

  // Drive the queued jobs with random bubbles/backpressure and compare against the model.
  task automatic run_jobs(input string name, input int ready_pct, input int bubble_pct, input int max_cyc);
    logic [NREQ-1:0]   hs = '0;
    logic [NREQ-1:0]   prev_rdy = '0;
    bit                at_start [NREQ];
    bit                hold_prev = 1'b0;
    bit                last_hs = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;
    logic [ID_W-1:0]   hold_id = '0;
    logic [CNT_W-1:0]  hold_cnt = '0;
    logic [NREQ-1:0]   want;
    int n_res = 0, n_gnt = 0, cyc = 0;
    for (int r = 0; r < NREQ; r++) at_start[r] = 1'b1;
    while (n_res < exp_id_q.size() && cyc < max_cyc) begin
      for (int r = 0; r < NREQ; r++) begin
        if (hs[r]) begin
          at_start[r] = last_q[r][0];
          void'(beat_q[r].pop_front());
          void'(last_q[r].pop_front());
        end
        if (beat_q[r].size() == 0) begin
          in_valid[r] = 1'b0;
        end else if (!(in_valid[r] && !hs[r])) begin
          in_data[r*DATA_W +: DATA_W] = beat_q[r][0];
          in_last[r]  = last_q[r][0];
          in_valid[r] = at_start[r] || ($urandom_range(99) >= bubble_pct);
        end
      end
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      checks++;
      if ($countones(in_ready) > 1) begin
        errors++; $display("FAIL %s onehot: in_ready=%b required at most one bit", name, in_ready);
      end
      checks++;
      if (busy !== ((in_ready != '0) || out_valid)) begin
        errors++; $display("FAIL %s busy: busy=%b in_ready=%b out_valid=%b", name, busy, in_ready, out_valid);
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== '0) begin
          errors++; $display("FAIL %s done_ready: in_ready=%b required 0 while out_valid", name, in_ready);
        end
      end
      if (last_hs) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL %s latency: out_valid=%b required 1 after last beat", name, out_valid);
        end
      end
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_id !== hold_id || out_cnt !== hold_cnt) begin
          errors++;
          $display("FAIL %s hold: got v=%b d=%h id=%0d cnt=%0d required v=1 d=%h id=%0d cnt=%0d",
                   name, out_valid, out_data, out_id, out_cnt, hold_data, hold_id, hold_cnt);
        end
      end
      if (prev_rdy == '0 && in_ready != '0) begin
        checks++;
        if (n_gnt >= exp_id_q.size()) begin
          errors++; $display("FAIL %s grant: unexpected grant in_ready=%b", name, in_ready);
        end else begin
          want = '0;
          want[exp_id_q[n_gnt]] = 1'b1;
          if (in_ready !== want) begin
            errors++; $display("FAIL %s grant: in_ready=%b required %b", name, in_ready, want);
          end
        end
        n_gnt++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (int'(out_id) !== exp_id_q[n_res] || out_data !== exp_sum_q[n_res] || int'(out_cnt) !== exp_cnt_q[n_res]) begin
          errors++;
          $display("FAIL %s result%0d: got id=%0d d=%h cnt=%0d required id=%0d d=%h cnt=%0d", name, n_res,
                   out_id, out_data, out_cnt, exp_id_q[n_res], exp_sum_q[n_res], exp_cnt_q[n_res]);
        end
        n_res++;
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data; hold_id = out_id; hold_cnt = out_cnt;
      hs       = in_valid & in_ready;
      last_hs  = |(hs & in_last);
      prev_rdy = in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (n_res != exp_id_q.size()) begin
      errors++; $display("FAIL %s timeout: results=%0d required %0d", name, n_res, exp_id_q.size());
    end
    in_valid  = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; in_last = '1; out_ready = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_during: v=%b d=%h rdy=%b busy=%b required all 0", out_valid, out_data, in_ready, busy);
      end
    end
    rst = 1'b0; in_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || out_cnt !== '0 || in_ready !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_after: v=%b d=%h id=%0d cnt=%0d rdy=%b busy=%b required all 0",
                           out_valid, out_data, out_id, out_cnt, in_ready, busy);
      end
    end
    model_ptr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 2; k++) begin
      push_beat(0, $urandom, 1'b1);
      push_beat(1, $urandom, 1'b1);
      push_beat(3, $urandom, 1'b1);
    end
    model_expect();
    run_jobs("round_robin", 100, 0, 200);
  endtask

  task automatic test_single_job();
    push_beat(2, 32'd5, 1'b0);
    push_beat(2, 32'd7, 1'b0);
    push_beat(2, -32'sd3, 1'b1);
    model_expect();
    run_jobs("single_job", 100, 0, 100);
  endtask

  task automatic test_wrap();
    push_beat(0, 32'h7FFF_FFFF, 1'b0);
    push_beat(0, 32'h0000_0002, 1'b1);
    push_beat(0, 32'hFFFF_FFFF, 1'b0);
    push_beat(0, 32'h0000_0001, 1'b1);
    model_expect();
    run_jobs("wrap", 100, 0, 100);
  endtask

  task automatic test_backpressure();
    push_rand_job(1, 4);
    push_rand_job(2, 1);
    model_expect();
    run_jobs("backpressure", 15, 50, 500);
  endtask

  task automatic test_random();
    int total;
    for (int round = 0; round < 4; round++) begin
      total = 0;
      for (int r = 0; r < NREQ; r++) begin
        for (int j = 0; j < int'($urandom_range(2)); j++) begin
          push_rand_job(r, $urandom_range(1, 18));
          total++;
        end
      end
      if (total == 0) push_rand_job(round % NREQ, 17);
      model_expect();
      run_jobs("random", 70, 30, 3000);
    end
  endtask

  task automatic test_reset_mid_job();
    bit found = 1'b0;
    in_valid = '0; in_last = '0; out_ready = 1'b1;
    in_valid[3] = 1'b1; in_data[3*DATA_W +: DATA_W] = 32'd10;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (in_ready[3]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL mid_job_grant: in_ready=%b required bit 3 set", in_ready);
    end
    @(posedge clk); #1;
    in_data[3*DATA_W +: DATA_W] = 32'd20;
    @(posedge clk); #1;
    in_valid = '0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_job_rst: rdy=%b v=%b required 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_job_abandon: v=%b busy=%b required 0", out_valid, busy);
      end
    end
    @(posedge clk); #1;
    model_ptr = 0;
    push_beat(3, 32'd1, 1'b0);
    push_beat(3, 32'd1, 1'b1);
    model_expect();
    run_jobs("mid_job_restart", 100, 0, 100);
  endtask

  initial begin
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_round_robin();
    test_single_job();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_job_arbiter.md
Name: acc_job_arbiter

Overview:
- Shares one 32-bit wrapping integer accumulator among NREQ requesters.
- Each requester streams a job (a sequence of int32 beats ending with a last flag).
- The block grants one job at a time in round-robin order, accumulates the job's beats, and returns the sum with the requester id and beat count.
- Sits between the vector-ALU input streams and the reduction result consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 32, beat and sum width.
- CNT_W, 16, width of the per-job beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NREQ  per-requester beat valid.
- in_data  input  NREQ*DATA_W  per-requester beat; requester i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  NREQ  marks the final beat of a job.
- in_ready  output  NREQ  per-requester beat accept.
- out_valid  output  1  result valid.
- out_data  output  DATA_W  job sum, modulo 2^DATA_W.
- out_id  output  clog2(NREQ)  requester index of the job.
- out_cnt  output  CNT_W  number of beats in the job, saturating.
- out_ready  input  1  consumer accept.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, acc=0, cnt=0.
  - out_valid=0, out_data=0, out_id=0, out_cnt=0, busy=0.
  - in_ready=0 while rst is high.
  - Reset mid-job abandons the job: partial sum discarded, no result emitted. Requesters still holding in_valid are re-arbitrated from rr_ptr=0.
- State machine:
  - IDLE: in_ready=0.
    - If any in_valid is set, pick the first set bit searching upward from rr_ptr with wrap. Register gnt=winner, acc=0, cnt=0, go to ACCUM.
    - If none is set, stay in IDLE.
  - ACCUM: in_ready[gnt]=in_ready combinational =1; all other in_ready bits=0.
    - On handshake (in_valid[gnt]&&in_ready[gnt]): acc<=acc+in_data[gnt], modulo 2^32, wraps silently. cnt<=cnt+1, saturating at 2^CNT_W-1.
    - If in_last[gnt] on a handshake:
      - out_data<=acc+beat, out_cnt<=cnt+1 (saturating), out_id<=gnt, out_valid<=1.
      - Go to DONE.
    - No handshake: hold state. Bubbles are allowed and do not end the job.
    - Other requesters' valid/last inputs are ignored.
  - DONE: in_ready all 0; out_valid=1 with out_data/out_id/out_cnt stable.
    - On out_ready: out_valid<=0, rr_ptr<=(gnt+1) mod NREQ, go to IDLE.
    - While out_ready=0, hold all outputs.
- Timing:
  - Throughput: 1 beat/cycle in ACCUM.
  - out_valid asserts the cycle after the last-beat handshake.
  - Minimum job-to-job overhead: 1 DONE cycle + 1 IDLE cycle.
  - A single-beat job (first beat has last=1) gives out_data=beat, out_cnt=1.
- Arithmetic: sum is two's-complement addition, no saturation, no overflow flag. Sign is irrelevant to the sum bits.
- Fairness: after requester k is served, k has lowest priority at the next arbitration. No requester starves while others have back-to-back jobs.
- Simultaneous events: the out_ready handshake and new in_valid in the same DONE cycle take effect in sequence. The new grant is evaluated in the following IDLE cycle, not in DONE.
- Requester inputs must be held stable while valid and not ready; the block does not check this.
- busy=1 exactly when state is ACCUM or DONE.

Test Plan:
- Reset check: assert rst 2 cycles with all inputs driven -> out_valid=0, out_data=0, in_ready=0, busy=0 during and after reset until the first in_valid.
- Single job: requester 2 sends 5,7,-3(last), no bubbles, out_ready=1 -> out_valid one cycle after the last beat with out_data=9, out_id=2, out_cnt=3. Only in_ready[2] is ever high.
- Wrap-around: requester 0 sends 0x7FFFFFFF,0x00000002(last) -> out_data=0x80000001. A second job 0xFFFFFFFF,0x00000001(last) -> out_data=0.
- Round-robin: requesters 0,1,3 hold one-beat jobs valid continuously -> grant order 0,1,3,0,1,3. Each result has the correct out_id.
- Backpressure and bubbles: requester 1 sends 4 beats with 2 idle cycles between beats 2 and 3; out_ready is held low 5 cycles -> out_data/out_id/out_cnt=4 stay stable; in_ready is all 0 during DONE; the next job starts only after out_ready.
- Reset mid-job: requester 3 sends 2 beats of a 4-beat job, then rst pulses 1 cycle -> no result is emitted. A restarted job 1,1(last) from requester 3 gives out_data=2, out_cnt=2.
